// File: rtl/decrypt_walker_pkg.sv
// Shared constants for the encrypt/decrypt memory walkers.
// Key, plaintext terminators and the one-hot walker state encoding.
package decrypt_walker_pkg;

    localparam logic [7:0] KEY    = 8'hA5;
    localparam logic [7:0] TERM_A = 8'h00;
    localparam logic [7:0] TERM_B = 8'h10;

    typedef enum logic [5:0] {
        S_IDLE  = 6'b000001,
        S_RADDR = 6'b000010,
        S_RDATA = 6'b000100,
        S_WRITE = 6'b001000,
        S_NEXT  = 6'b010000,
        S_DONE  = 6'b100000
    } state_t;

    function automatic logic is_term(input logic [7:0] b);
        return (b == TERM_A) || (b == TERM_B);
    endfunction

endpackage

// File: rtl/decrypt_walker_byte.sv
// Single-byte decryptor, the mirror of the encrypt unit.
// Undo the key XOR, then rotate right by one.
module decrypt_byte
    import decrypt_walker_pkg::*;
#(
    parameter logic [7:0] K = KEY
) (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    logic [7:0] t;

    // Purely combinational: t = din ^ K, dout = ror1(t)
    always_comb begin
        t    = din ^ K;
        dout = {t[0], t[7:1]};
    end

endmodule

// File: rtl/decrypt_walker.sv
// Memory-walking decryptor: reads, decrypts and writes back bytes
// in place from start_addr until a plaintext terminator is written.
module decrypt_walker
    import decrypt_walker_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] start_addr,
    output logic [7:0] mem_addr,
    output logic       mem_we,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic       busy,
    output logic       done,
    output logic       wrapped,
    output logic [7:0] count,
    output logic [7:0] state_leds
);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] ptr_q;
    logic [7:0] data_q;
    logic [7:0] count_q;
    logic       wrapped_q;
    logic [7:0] dec;

    decrypt_byte #(.K(KEY)) u_dec (
        .din  (mem_rdata),
        .dout (dec)
    );

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control outputs
    always_comb begin
        state_d = state_q;
        mem_we  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RADDR;
            end
            S_RADDR: begin
                busy    = 1'b1;
                state_d = S_RDATA;
            end
            S_RDATA: begin
                busy    = 1'b1;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                busy    = 1'b1;
                mem_we  = 1'b1;
                state_d = is_term(data_q) ? S_DONE : S_NEXT;
            end
            S_NEXT: begin
                busy    = 1'b1;
                state_d = (ptr_q == 8'hFF) ? S_DONE : S_RADDR;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_d = S_RADDR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pointer, data latch, element count and wrap flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q     <= 8'h00;
            data_q    <= 8'h00;
            count_q   <= 8'h00;
            wrapped_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        ptr_q     <= start_addr;
                        count_q   <= 8'h00;
                        wrapped_q <= 1'b0;
                    end
                end
                S_RDATA: data_q <= dec;
                S_WRITE: begin
                    if (count_q != 8'hFF) count_q <= count_q + 8'h01;
                end
                S_NEXT: begin
                    ptr_q <= ptr_q + 8'h01;
                    if (ptr_q == 8'hFF) wrapped_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr   = ptr_q;
    assign mem_wdata  = data_q;
    assign count      = count_q;
    assign wrapped    = wrapped_q;
    assign state_leds = {2'b00, state_q};

endmodule
